// File: rtl/ring_queue.sv
// Circular FIFO with first-word-fall-through read data, full-depth capacity and
// a selectable full policy (overwrite-oldest or reject-newest) plus drop accounting.
module ring_queue #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 512,
  parameter bit OVERWRITE   = 1'b1,
  parameter int AFULL_LEVEL = DEPTH - 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       we,
  input  logic [WIDTH-1:0]           wd,
  input  logic                       re,
  output logic [WIDTH-1:0]           rd,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       ovf_clear,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_COUNT = CW'(AFULL_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [15:0]      r_dropCount;

  logic w_full;
  logic w_read;
  logic w_drop;
  logic w_store;
  logic w_headAdv;

  // A drop is any write that finds the queue full with no same-cycle pop to make
  // room; in overwrite mode the drop is the oldest entry, so head moves too.
  always_comb begin
    w_full    = (r_count == FULL_COUNT);
    w_read    = re && (r_count != '0);
    w_drop    = we && w_full && !re;
    w_store   = we && (!w_full || re || OVERWRITE);
    w_headAdv = w_read || (w_drop && OVERWRITE);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store)   r_tail <= r_tail + AW'(1);
      if (w_headAdv) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_store) - CW'(w_headAdv);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && w_store) r_mem[r_tail] <= wd;
  end

  // Flush leaves the overflow bookkeeping alone; a drop beats a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (w_drop && !flush) begin
      r_overflow <= 1'b1;
      if (ovf_clear)                  r_dropCount <= 16'd1;
      else if (r_dropCount != 16'hFFFF) r_dropCount <= r_dropCount + 16'd1;
    end else if (ovf_clear) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end
  end

  assign rd          = r_mem[r_head];
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = w_full;
  assign almost_full = (r_count >= AFULL_COUNT);
  assign overflow    = r_overflow;
  assign drop_count  = r_dropCount;

endmodule
